// File: rtl/wash_pkg.sv
// wash_pkg: shared state encodings, error codes and helpers for the washing-machine controller.
package wash_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_FILL  = 4'd1,
        S_WASH  = 4'd2,
        S_RINSE = 4'd3,
        S_DRAIN = 4'd4,
        S_SPIN  = 4'd5,
        S_DONE  = 4'd6,
        S_PAUSE = 4'd7,
        S_ERROR = 4'd8
    } state_t;

    localparam logic [1:0] E_NONE  = 2'd0;
    localparam logic [1:0] E_DOOR  = 2'd1;
    localparam logic [1:0] E_FILL  = 2'd2;
    localparam logic [1:0] E_DRAIN = 2'd3;

    // Phases that a door opening suspends instead of aborting.
    function automatic logic is_pausable(input state_t s);
        return s == S_FILL || s == S_WASH || s == S_RINSE || s == S_DRAIN;
    endfunction

endpackage

// File: rtl/wash_ctrl_param_timer.sv
// phase_timer: saturating up-counter used to time each washing phase.
//   clk, rst : clock and async active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : count enable
//   cnt      : elapsed count, sticks at all-ones
module phase_timer #(
    parameter int TIMER_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    output logic [TIMER_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != '1)
            cnt <= cnt + TIMER_W'(1);

endmodule

// File: rtl/wash_ctrl_param.sv
// wash_ctrl_param: washing-machine sequencer with internal phase timing, rinse passes,
// door pause/resume and fill/drain timeouts.
//   clk, rst                     : clock, async active-high reset
//   start, door_closed           : front panel / door latch
//   water_level, water_empty     : drum sensors
//   state                        : current state encoding
//   motor_on, water_valve,
//   drain_valve, buzzer          : actuators, Moore decode of state
//   rinse_idx                    : rinse passes completed
//   timer                        : elapsed clocks in current phase
//   error_code                   : 0 none, 1 door, 2 fill timeout, 3 drain timeout
module wash_ctrl_param
    import wash_pkg::*;
#(
    parameter int TIMER_W       = 16,
    parameter int WASH_CYCLES   = 500,
    parameter int RINSE_CYCLES  = 300,
    parameter int SPIN_CYCLES   = 400,
    parameter int FILL_TIMEOUT  = 1000,
    parameter int DRAIN_TIMEOUT = 800,
    parameter int NUM_RINSE     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               door_closed,
    input  logic               water_level,
    input  logic               water_empty,
    output logic [3:0]         state,
    output logic               motor_on,
    output logic               water_valve,
    output logic               drain_valve,
    output logic               buzzer,
    output logic [2:0]         rinse_idx,
    output logic [TIMER_W-1:0] timer,
    output logic [1:0]         error_code
);

    localparam logic [TIMER_W-1:0] WASH_END  = TIMER_W'(WASH_CYCLES - 1);
    localparam logic [TIMER_W-1:0] RINSE_END = TIMER_W'(RINSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SPIN_END  = TIMER_W'(SPIN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] FILL_END  = TIMER_W'(FILL_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] DRAIN_END = TIMER_W'(DRAIN_TIMEOUT - 1);

    state_t       cur, nxt, saved;
    logic [2:0]   ri_nxt;
    logic [1:0]   err_nxt;
    logic         washed, washed_nxt;
    logic         clr, en;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cur        <= S_IDLE;
            saved      <= S_IDLE;
            rinse_idx  <= '0;
            error_code <= E_NONE;
            washed     <= 1'b0;
        end else begin
            cur        <= nxt;
            rinse_idx  <= ri_nxt;
            error_code <= err_nxt;
            washed     <= washed_nxt;
            if (nxt == S_PAUSE && cur != S_PAUSE)
                saved <= cur;
        end

    // Door checks come first in every branch so they beat completion and timeout;
    // sensor checks precede timeouts so a same-cycle answer still wins.
    always_comb begin
        nxt        = cur;
        ri_nxt     = rinse_idx;
        err_nxt    = error_code;
        washed_nxt = washed;
        case (cur)
            S_IDLE:
                if (start && door_closed) begin
                    nxt        = S_FILL;
                    ri_nxt     = '0;
                    err_nxt    = E_NONE;
                    washed_nxt = 1'b0;
                end else if (start) begin
                    nxt     = S_ERROR;
                    err_nxt = E_DOOR;
                end
            S_FILL:
                if (!door_closed)
                    nxt = S_PAUSE;
                else if (water_level)
                    nxt = washed ? S_RINSE : S_WASH;
                else if (timer == FILL_END) begin
                    nxt     = S_ERROR;
                    err_nxt = E_FILL;
                end
            S_WASH:
                if (!door_closed)
                    nxt = S_PAUSE;
                else if (timer == WASH_END) begin
                    nxt        = S_DRAIN;
                    washed_nxt = 1'b1;
                end
            S_RINSE:
                if (!door_closed)
                    nxt = S_PAUSE;
                else if (timer == RINSE_END)
                    nxt = S_DRAIN;
            S_DRAIN:
                if (!door_closed)
                    nxt = S_PAUSE;
                else if (water_empty) begin
                    nxt    = rinse_idx < 3'(NUM_RINSE) ? S_FILL : S_SPIN;
                    ri_nxt = rinse_idx < 3'(NUM_RINSE) ? rinse_idx + 3'd1 : rinse_idx;
                end else if (timer == DRAIN_END) begin
                    nxt     = S_ERROR;
                    err_nxt = E_DRAIN;
                end
            S_SPIN:
                if (!door_closed) begin
                    nxt     = S_ERROR;
                    err_nxt = E_DOOR;
                end else if (timer == SPIN_END)
                    nxt = S_DONE;
            S_PAUSE:
                nxt = door_closed && start ? saved : S_PAUSE;
            S_DONE, S_ERROR:
                nxt = start ? cur : S_IDLE;
            default:
                nxt = S_IDLE;
        endcase
    end

    // Entering or leaving PAUSE keeps the count so the phase resumes where it stopped.
    assign clr = nxt != cur && nxt != S_PAUSE && cur != S_PAUSE;
    assign en  = is_pausable(cur) || cur == S_SPIN;

    phase_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (en),
        .cnt (timer)
    );

    assign state       = cur;
    assign motor_on    = cur == S_WASH || cur == S_RINSE || cur == S_SPIN;
    assign water_valve = cur == S_FILL;
    assign drain_valve = cur == S_DRAIN || cur == S_SPIN;
    assign buzzer      = cur == S_DONE || cur == S_ERROR;

endmodule

// File: tb/tb_wash_ctrl_param.sv
// tb_wash_ctrl_param: random and directed stimulus for two controller instances
// (two rinses and no rinse) checked every cycle against a behavioural model.
module tb_wash_ctrl_param;

    localparam int TW = 8, WC = 4, RC = 3, SC = 5, FT = 8, DT = 6, NR = 2;
    localparam int TMAX = (1 << TW) - 1;
    localparam int LIM [0:8] = '{0, FT, WC, RC, DT, SC, 0, 0, 0};

    logic clk = 0, rst = 1, start = 0, door_closed = 1, water_level = 0, water_empty = 0;
    logic [3:0] state1, state2;
    logic mo1, mo2, wv1, wv2, dv1, dv2, bz1, bz2;
    logic [2:0] ri1, ri2;
    logic [TW-1:0] tm1, tm2;
    logic [1:0] ec1, ec2;
    int checks = 0, errors = 0;
    bit auto_sns = 0, saw_r2 = 0;

    typedef struct {int st; int tmr; int ri; int err; int saved; bit washed;} m_t;
    m_t m1, m2;

    always #5 clk = ~clk;

    wash_ctrl_param #(.TIMER_W(TW), .WASH_CYCLES(WC), .RINSE_CYCLES(RC), .SPIN_CYCLES(SC),
        .FILL_TIMEOUT(FT), .DRAIN_TIMEOUT(DT), .NUM_RINSE(NR)) u1 (
        .clk(clk), .rst(rst), .start(start), .door_closed(door_closed),
        .water_level(water_level), .water_empty(water_empty), .state(state1),
        .motor_on(mo1), .water_valve(wv1), .drain_valve(dv1), .buzzer(bz1),
        .rinse_idx(ri1), .timer(tm1), .error_code(ec1));

    wash_ctrl_param #(.TIMER_W(TW), .WASH_CYCLES(WC), .RINSE_CYCLES(RC), .SPIN_CYCLES(SC),
        .FILL_TIMEOUT(FT), .DRAIN_TIMEOUT(DT), .NUM_RINSE(0)) u0 (
        .clk(clk), .rst(rst), .start(start), .door_closed(door_closed),
        .water_level(water_level), .water_empty(water_empty), .state(state2),
        .motor_on(mo2), .water_valve(wv2), .drain_valve(dv2), .buzzer(bz2),
        .rinse_idx(ri2), .timer(tm2), .error_code(ec2));

    // One clock of the washing programme, expressed as phase rules:
    // 0 idle, 1 fill, 2 wash, 3 rinse, 4 drain, 5 spin, 6 done, 7 pause, 8 error.
    function automatic m_t step(m_t m, bit s, bit d, bit l, bit e, int nr);
        m_t n = m;
        bit fin = m.tmr == LIM[m.st] - 1;
        case (m.st)
            0: if (s) begin
                   if (d) begin n.st = 1; n.ri = 0; n.err = 0; n.washed = 0; end
                   else begin n.st = 8; n.err = 1; end
               end
            1, 2, 3, 4:
               if (!d) begin n.st = 7; n.saved = m.st; end
               else if (m.st == 1 && l) n.st = m.washed ? 3 : 2;
               else if (m.st == 4 && e) begin
                   if (m.ri < nr) begin n.st = 1; n.ri = m.ri + 1; end
                   else n.st = 5;
               end else if (fin) begin
                   n.st = (m.st == 1 || m.st == 4) ? 8 : 4;
                   if (m.st == 1) n.err = 2;
                   if (m.st == 4) n.err = 3;
                   if (m.st == 2) n.washed = 1;
               end
            5: if (!d) begin n.st = 8; n.err = 1; end
               else if (fin) n.st = 6;
            6, 8: if (!s) n.st = 0;
            7: if (d && s) n.st = m.saved;
            default: n.st = 0;
        endcase
        if (n.st != m.st && n.st != 7 && m.st != 7) n.tmr = 0;
        else if (m.st >= 1 && m.st <= 5) n.tmr = m.tmr < TMAX ? m.tmr + 1 : TMAX;
        return n;
    endfunction

    always @(posedge clk or posedge rst)
        if (rst) begin
            m1 <= '{default: 0};
            m2 <= '{default: 0};
        end else begin
            m1 <= step(m1, start, door_closed, water_level, water_empty, NR);
            m2 <= step(m2, start, door_closed, water_level, water_empty, 0);
        end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input string u, input int s, input int mo, input int wv, input int dv,
                       input int bz, input int ri, input int tm, input int ec, input m_t m);
        chk({u, ".state"}, s, m.st);
        chk({u, ".motor_on"}, mo, int'(m.st == 2 || m.st == 3 || m.st == 5));
        chk({u, ".water_valve"}, wv, int'(m.st == 1));
        chk({u, ".drain_valve"}, dv, int'(m.st == 4 || m.st == 5));
        chk({u, ".buzzer"}, bz, int'(m.st == 6 || m.st == 8));
        chk({u, ".rinse_idx"}, ri, m.ri);
        chk({u, ".timer"}, tm, m.tmr);
        chk({u, ".error_code"}, ec, m.err);
    endtask

    always @(negedge clk) begin
        cmp("u1", int'(state1), int'(mo1), int'(wv1), int'(dv1), int'(bz1), int'(ri1), int'(tm1), int'(ec1), m1);
        cmp("u0", int'(state2), int'(mo2), int'(wv2), int'(dv2), int'(bz2), int'(ri2), int'(tm2), int'(ec2), m2);
        if (state2 == 4'd3) saw_r2 = 1;
    end

    // Sensors answer on the second clock of FILL / DRAIN when auto_sns is set.
    task automatic tick();
        @(negedge clk);
        if (auto_sns) begin
            water_level = m1.st == 1 && m1.tmr == 1;
            water_empty = m1.st == 4 && m1.tmr == 1;
        end
    endtask

    task automatic wait_m(input int st, input int tmr, input int budget, input string nm);
        int n = 0;
        tick();
        while (!(m1.st == st && (tmr < 0 || m1.tmr == tmr)) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk({nm, ".reached"}, m1.st, st);
    endtask

    int tr_st[$], tr_len[$];
    int exp_st [0:10] = '{1, 2, 4, 1, 3, 4, 1, 3, 4, 5, 6};
    int exp_len [0:9] = '{2, 4, 2, 2, 3, 2, 2, 3, 2, 5};

    initial begin
        int cnt;
        tick();
        chk("reset.state", int'(state1), 0);
        chk("reset.timer", int'(tm1), 0);
        chk("reset.buzzer", int'(bz1), 0);
        rst = 0;
        tick();
        // nominal programme with two rinses
        auto_sns = 1;
        start = 1;
        for (int k = 0; k < 200 && state1 != 4'd6; k++) begin
            tick();
            if (state1 != 4'd0) begin
                if (tr_st.size() == 0 || tr_st[tr_st.size()-1] != int'(state1)) begin
                    tr_st.push_back(int'(state1));
                    tr_len.push_back(1);
                end else
                    tr_len[tr_len.size()-1] = tr_len[tr_len.size()-1] + 1;
            end
        end
        chk("nom.phases", tr_st.size(), 11);
        for (int i = 0; i < 11; i++)
            if (i < tr_st.size()) chk($sformatf("nom.phase%0d", i), tr_st[i], exp_st[i]);
        for (int i = 0; i < 10; i++)
            if (i < tr_len.size()) chk($sformatf("nom.len%0d", i), tr_len[i], exp_len[i]);
        chk("nom.buzzer", int'(bz1), 1);
        chk("nom.rinse_idx", int'(ri1), 2);
        chk("nr0.state", int'(state2), 6);
        chk("nr0.rinse_idx", int'(ri2), 0);
        start = 0;
        tick();
        chk("nom.idle", int'(state1), 0);
        // door opened on the first WASH clock, closed ten clocks later
        start = 1;
        wait_m(2, 0, 100, "pause");
        door_closed = 0;
        tick();
        chk("pause.state", int'(state1), 7);
        chk("pause.motor", int'(mo1), 0);
        chk("pause.timer", int'(tm1), 1);
        repeat (9) tick();
        chk("pause.frozen", int'(tm1), 1);
        door_closed = 1;
        tick();
        cnt = 0;
        while (state1 == 4'd2 && cnt < 20) begin
            cnt++;
            tick();
        end
        chk("pause.wash_left", cnt, 3);
        wait_m(6, -1, 200, "pause.done");
        start = 0;
        tick();
        // door opened during spin
        start = 1;
        wait_m(5, -1, 200, "spin");
        door_closed = 0;
        tick();
        chk("spin.state", int'(state1), 8);
        chk("spin.error", int'(ec1), 1);
        chk("spin.buzzer", int'(bz1), 1);
        chk("spin.motor", int'(mo1), 0);
        start = 0;
        door_closed = 1;
        tick();
        // fill timeout
        auto_sns = 0;
        water_level = 0;
        water_empty = 0;
        start = 1;
        tick();
        cnt = 0;
        while (state1 == 4'd1 && cnt < 30) begin
            cnt++;
            tick();
        end
        chk("fill.clocks", cnt, FT);
        chk("fill.state", int'(state1), 8);
        chk("fill.error", int'(ec1), 2);
        start = 0;
        tick();
        start = 1;
        tick();
        while (m1.st == 1 && m1.tmr < FT - 1) tick();
        water_level = 1;
        tick();
        water_level = 0;
        chk("fill.late_level", int'(state1), 2);
        chk("fill.error_cleared", int'(ec1), 0);
        // async reset in the middle of a rinse
        auto_sns = 1;
        wait_m(3, 1, 200, "rst.rinse");
        @(posedge clk);
        #3 rst = 1;
        #1;
        chk("rst.state", int'(state1), 0);
        chk("rst.timer", int'(tm1), 0);
        chk("rst.motor", int'(mo1), 0);
        chk("rst.rinse_idx", int'(ri1), 0);
        tick();
        rst = 0;
        tick();
        chk("rst.restart", int'(state1), 1);
        // random soak
        auto_sns = 0;
        for (int k = 0; k < 3000; k++) begin
            tick();
            start = $urandom_range(0, 9) < 8;
            door_closed = $urandom_range(0, 19) != 0;
            water_level = $urandom_range(0, 3) == 0;
            water_empty = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1;
                #2 rst = 0;
            end
        end
        tick();
        chk("nr0.no_rinse", int'(saw_r2), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
